// File: rtl/frequency_analyzer_sequencer.sv
// Control sequencer for the frequency analyzer: latches a configuration,
// pulses the analyzer clear, opens an enable window of exactly W clocks,
// then captures f0/f1 results with a done pulse and a dominant-tone code.
module frequency_analyzer_sequencer #(
   parameter int WIDTH                 = 32,
   parameter int DEFAULT_WINDOW_CYCLES = 1000000,
   parameter int CLEAR_CYCLES          = 4,
   parameter int SETTLE_CYCLES         = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic [31:0]      window_cycles,
   input  logic [WIDTH-1:0] f0_cfg,
   input  logic [WIDTH-1:0] f1_cfg,
   input  logic [WIDTH-1:0] deviation_cfg,
   input  logic [WIDTH-1:0] f0_value,
   input  logic [WIDTH-1:0] f1_value,
   output logic             analyzer_enable,
   output logic             analyzer_clear,
   output logic [WIDTH-1:0] analyzer_f0,
   output logic [WIDTH-1:0] analyzer_f1,
   output logic [WIDTH-1:0] analyzer_deviation,
   output logic             busy,
   output logic             done,
   output logic             result_valid,
   output logic             aborted,
   output logic [WIDTH-1:0] f0_result,
   output logic [WIDTH-1:0] f1_result,
   output logic [1:0]       dominant
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_SETTLE_A,
      S_MEASURE,
      S_SETTLE_B,
      S_CAPTURE
   } state_t;

   // Down-counter reload values; each phase runs load+1 clocks.
   localparam logic [31:0] CLR_LOAD = 32'(CLEAR_CYCLES - 1);
   localparam logic [31:0] SET_LOAD = 32'(SETTLE_CYCLES - 1);
   localparam logic [31:0] DEF_WIN  = 32'(DEFAULT_WINDOW_CYCLES);

   state_t           state_q, state_d;
   logic [31:0]      cnt_q, cnt_d;
   logic [31:0]      win_q, win_d;
   logic             enable_q, enable_d;
   logic             clear_q, clear_d;
   logic [WIDTH-1:0] f0_cfg_q, f0_cfg_d;
   logic [WIDTH-1:0] f1_cfg_q, f1_cfg_d;
   logic [WIDTH-1:0] dev_cfg_q, dev_cfg_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             valid_q, valid_d;
   logic             aborted_q, aborted_d;
   logic [WIDTH-1:0] f0_res_q, f0_res_d;
   logic [WIDTH-1:0] f1_res_q, f1_res_d;
   logic [1:0]       dom_q, dom_d;

   // Dominant-tone code: 00 both zero, 01 f0 larger, 10 f1 larger, 11 equal nonzero.
   function automatic logic [1:0] classify(input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b);
      logic [1:0] code;
      if (a == '0 && b == '0) begin
         code = 2'b00;
      end else if (a > b) begin
         code = 2'b01;
      end else if (b > a) begin
         code = 2'b10;
      end else begin
         code = 2'b11;
      end
      return code;
   endfunction

   // Next-state and registered-output computation; abort overrides every active phase.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      win_d     = win_q;
      enable_d  = 1'b0;
      clear_d   = 1'b0;
      f0_cfg_d  = f0_cfg_q;
      f1_cfg_d  = f1_cfg_q;
      dev_cfg_d = dev_cfg_q;
      done_d    = 1'b0;
      valid_d   = valid_q;
      aborted_d = 1'b0;
      f0_res_d  = f0_res_q;
      f1_res_d  = f1_res_q;
      dom_d     = dom_q;

      case (state_q)
         S_IDLE: begin
            if (start && !abort) begin
               f0_cfg_d  = f0_cfg;
               f1_cfg_d  = f1_cfg;
               dev_cfg_d = deviation_cfg;
               win_d     = (window_cycles == 32'd0) ? DEF_WIN : window_cycles;
               valid_d   = 1'b0;
               cnt_d     = CLR_LOAD;
               clear_d   = 1'b1;
               state_d   = S_CLEAR;
            end
         end
         S_CLEAR: begin
            if (cnt_q == 32'd0) begin
               cnt_d   = SET_LOAD;
               state_d = S_SETTLE_A;
            end else begin
               cnt_d   = cnt_q - 32'd1;
               clear_d = 1'b1;
            end
         end
         S_SETTLE_A: begin
            if (cnt_q == 32'd0) begin
               cnt_d    = win_q - 32'd1;
               enable_d = 1'b1;
               state_d  = S_MEASURE;
            end else begin
               cnt_d = cnt_q - 32'd1;
            end
         end
         S_MEASURE: begin
            if (cnt_q == 32'd0) begin
               cnt_d   = SET_LOAD;
               state_d = S_SETTLE_B;
            end else begin
               cnt_d    = cnt_q - 32'd1;
               enable_d = 1'b1;
            end
         end
         S_SETTLE_B: begin
            if (cnt_q == 32'd0) begin
               state_d = S_CAPTURE;
            end else begin
               cnt_d = cnt_q - 32'd1;
            end
         end
         S_CAPTURE: begin
            f0_res_d = f0_value;
            f1_res_d = f1_value;
            dom_d    = classify(f0_value, f1_value);
            done_d   = 1'b1;
            valid_d  = 1'b1;
            state_d  = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (state_q != S_IDLE && abort) begin
         state_d   = S_IDLE;
         cnt_d     = 32'd0;
         enable_d  = 1'b0;
         clear_d   = 1'b0;
         done_d    = 1'b0;
         aborted_d = 1'b1;
         valid_d   = valid_q;
         f0_res_d  = f0_res_q;
         f1_res_d  = f1_res_q;
         dom_d     = dom_q;
      end

      busy_d = (state_d != S_IDLE);
   end

   // State and output registers; reset clears everything immediately.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= 32'd0;
         win_q     <= 32'd0;
         enable_q  <= 1'b0;
         clear_q   <= 1'b0;
         f0_cfg_q  <= '0;
         f1_cfg_q  <= '0;
         dev_cfg_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         valid_q   <= 1'b0;
         aborted_q <= 1'b0;
         f0_res_q  <= '0;
         f1_res_q  <= '0;
         dom_q     <= 2'b00;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         win_q     <= win_d;
         enable_q  <= enable_d;
         clear_q   <= clear_d;
         f0_cfg_q  <= f0_cfg_d;
         f1_cfg_q  <= f1_cfg_d;
         dev_cfg_q <= dev_cfg_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         valid_q   <= valid_d;
         aborted_q <= aborted_d;
         f0_res_q  <= f0_res_d;
         f1_res_q  <= f1_res_d;
         dom_q     <= dom_d;
      end
   end

   assign analyzer_enable    = enable_q;
   assign analyzer_clear     = clear_q;
   assign analyzer_f0        = f0_cfg_q;
   assign analyzer_f1        = f1_cfg_q;
   assign analyzer_deviation = dev_cfg_q;
   assign busy               = busy_q;
   assign done               = done_q;
   assign result_valid       = valid_q;
   assign aborted            = aborted_q;
   assign f0_result          = f0_res_q;
   assign f1_result          = f1_res_q;
   assign dominant           = dom_q;

endmodule

// File: tb/tb_frequency_analyzer_sequencer.sv
// Bench for frequency_analyzer_sequencer: table of runs with a result
// scoreboard, plus hand sequences for abort, held start and mid-run reset.
module tb_frequency_analyzer_sequencer;

   localparam int WIDTH = 32;
   localparam int DEFW  = 50;
   localparam int CLR   = 4;
   localparam int SET   = 2;

   logic             clock = 1'b0;
   logic             reset = 1'b0;
   logic             start = 1'b0;
   logic             abort = 1'b0;
   logic [31:0]      window_cycles = '0;
   logic [WIDTH-1:0] f0_cfg = '0, f1_cfg = '0, deviation_cfg = '0;
   logic [WIDTH-1:0] f0_value = '0, f1_value = '0;
   logic             analyzer_enable, analyzer_clear, busy, done, result_valid, aborted;
   logic [WIDTH-1:0] analyzer_f0, analyzer_f1, analyzer_deviation, f0_result, f1_result;
   logic [1:0]       dominant;

   always #5 clock = ~clock;

   frequency_analyzer_sequencer #(
      .WIDTH(WIDTH), .DEFAULT_WINDOW_CYCLES(DEFW),
      .CLEAR_CYCLES(CLR), .SETTLE_CYCLES(SET)
   ) dut (
      .clock(clock), .reset(reset), .start(start), .abort(abort),
      .window_cycles(window_cycles), .f0_cfg(f0_cfg), .f1_cfg(f1_cfg),
      .deviation_cfg(deviation_cfg), .f0_value(f0_value), .f1_value(f1_value),
      .analyzer_enable(analyzer_enable), .analyzer_clear(analyzer_clear),
      .analyzer_f0(analyzer_f0), .analyzer_f1(analyzer_f1),
      .analyzer_deviation(analyzer_deviation), .busy(busy), .done(done),
      .result_valid(result_valid), .aborted(aborted),
      .f0_result(f0_result), .f1_result(f1_result), .dominant(dominant)
   );

   typedef struct {
      logic [31:0]      win;
      logic [WIDTH-1:0] f0c, f1c, devc, v0, v1;
      int               eff_w;
      logic [1:0]       dom;
   } vec_t;

   typedef struct {
      logic [WIDTH-1:0] f0, f1;
      logic [1:0]       dom;
   } exp_t;

   vec_t vecs[6];
   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

   function automatic vec_t mk(input logic [31:0] win, input logic [WIDTH-1:0] f0c,
                               input logic [WIDTH-1:0] f1c, input logic [WIDTH-1:0] devc,
                               input logic [WIDTH-1:0] v0, input logic [WIDTH-1:0] v1,
                               input int eff_w, input logic [1:0] dom);
      vec_t v;
      v.win = win; v.f0c = f0c; v.f1c = f1c; v.devc = devc;
      v.v0 = v0; v.v1 = v1; v.eff_w = eff_w; v.dom = dom;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic check_zero(input string tag);
      chk($sformatf("%s_ctrl", tag),
          {58'd0, analyzer_enable, analyzer_clear, busy, done, result_valid, aborted}, 64'd0);
      chk($sformatf("%s_cfg_f0", tag), analyzer_f0, 0);
      chk($sformatf("%s_cfg_f1", tag), analyzer_f1, 0);
      chk($sformatf("%s_cfg_dev", tag), analyzer_deviation, 0);
      chk($sformatf("%s_f0_result", tag), f0_result, 0);
      chk($sformatf("%s_f1_result", tag), f1_result, 0);
      chk($sformatf("%s_dominant", tag), dominant, 0);
   endtask

   // Called at a negedge with the DUT idle; returns at the done negedge (hold)
   // or one clock later with start released.
   task automatic run_vec(input vec_t v, input bit hold);
      exp_t e;
      exp_t p;
      int   k, nclr, nen, bad;
      bit   got;
      window_cycles = v.win; f0_cfg = v.f0c; f1_cfg = v.f1c; deviation_cfg = v.devc;
      f0_value = v.v0; f1_value = v.v1;
      start = 1'b1;
      e.f0 = v.v0; e.f1 = v.v1; e.dom = v.dom;
      sb.push_back(e);
      @(posedge clock);
      k = 0; nclr = 0; nen = 0; bad = 0; got = 1'b0;
      while (k < v.eff_w + 40) begin
         @(negedge clock);
         if (k == 0) begin
            if (!hold) start = 1'b0;
            chk("busy_on_start", busy, 1);
            chk("clear_on_start", analyzer_clear, 1);
            chk("valid_cleared_on_start", result_valid, 0);
         end
         if (k == 10) begin
            f0_cfg = ~f0_cfg; f1_cfg = f1_cfg + 1; deviation_cfg = deviation_cfg ^ 32'h5;
         end
         if (done) begin
            got = 1'b1;
            break;
         end
         nclr += analyzer_clear;
         nen  += analyzer_enable;
         if (analyzer_f0 !== v.f0c || analyzer_f1 !== v.f1c || analyzer_deviation !== v.devc)
            bad++;
         @(posedge clock);
         k++;
      end
      p = sb.pop_front();
      chk("done_seen", got, 1);
      chk("done_latency", k, CLR + 2 * SET + v.eff_w + 1);
      chk("clear_cycles", nclr, CLR);
      chk("enable_cycles", nen, v.eff_w);
      chk("cfg_stable_cycles_bad", bad, 0);
      if (got) begin
         chk("f0_result", f0_result, p.f0);
         chk("f1_result", f1_result, p.f1);
         chk("dominant", dominant, p.dom);
         chk("result_valid_at_done", result_valid, 1);
         chk("no_abort_at_done", aborted, 0);
      end
      if (!hold) begin
         @(posedge clock);
         @(negedge clock);
         chk("done_one_clock", done, 0);
         chk("idle_after_done", busy, 0);
         chk("valid_holds", result_valid, 1);
         chk("cfg_held_idle", analyzer_f0, v.f0c);
      end
   endtask

   // Starts a run and raises abort at negedge index at_k after the start edge.
   task automatic run_abort(input logic [31:0] win, input int at_k, input bit expect_en,
                            input logic [WIDTH-1:0] prev_f0, input logic [WIDTH-1:0] prev_f1);
      int ndone;
      window_cycles = win; f0_value = 32'hAAAA; f1_value = 32'h5555;
      start = 1'b1;
      @(posedge clock);
      @(negedge clock);
      start = 1'b0;
      repeat (at_k) begin
         @(posedge clock);
         @(negedge clock);
      end
      chk("abort_pre_busy", busy, 1);
      chk("abort_pre_done", done, 0);
      if (expect_en) chk("abort_pre_enable", analyzer_enable, 1);
      abort = 1'b1;
      @(posedge clock);
      @(negedge clock);
      abort = 1'b0;
      chk("aborted_pulse", aborted, 1);
      chk("abort_enable_low", analyzer_enable, 0);
      chk("abort_clear_low", analyzer_clear, 0);
      chk("abort_idle", busy, 0);
      chk("abort_no_done", done, 0);
      @(posedge clock);
      @(negedge clock);
      chk("aborted_one_clock", aborted, 0);
      ndone = 0;
      repeat (int'(win) + 30) begin
         @(posedge clock);
         @(negedge clock);
         ndone += done;
      end
      chk("no_done_after_abort", ndone, 0);
      chk("abort_valid_low", result_valid, 0);
      chk("abort_f0_retained", f0_result, prev_f0);
      chk("abort_f1_retained", f1_result, prev_f1);
   endtask

   initial begin
      int acc;
      vecs[0] = mk(32'd100, 32'd5000, 32'd10000, 32'd10, 32'd37, 32'd12, 100, 2'b01);
      vecs[1] = mk(32'd0, 32'd1, 32'd2, 32'd3, 32'd7, 32'd7, DEFW, 2'b11);
      vecs[2] = mk(32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, DEFW, 2'b00);
      vecs[3] = mk(32'd5, 32'h1234, 32'h4321, 32'h77, 32'd3, 32'd9, 5, 2'b10);
      vecs[4] = mk(32'd1, 32'hFFFFFFFF, 32'h80000000, 32'hFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1, 2'b01);
      vecs[5] = mk(32'd3, 32'd9, 32'd8, 32'd1, 32'd0, 32'd1, 3, 2'b10);

      // Power-on reset with the clock running.
      repeat (3) @(negedge clock);
      check_zero("por");
      reset = 1'b1;
      @(negedge clock);

      // Table of nominal runs.
      for (int i = 0; i < 6; i++) run_vec(vecs[i], 1'b0);

      // Aborts in MEASURE (30th window clock), CAPTURE and CLEAR, then recovery.
      run_vec(vecs[0], 1'b0);
      run_abort(32'd100, 35, 1'b1, 32'd37, 32'd12);
      run_abort(32'd2, CLR + 2 * SET + 2, 1'b0, 32'd37, 32'd12);
      run_abort(32'd5, 1, 1'b0, 32'd37, 32'd12);
      run_vec(vecs[1], 1'b0);

      // start and abort together in IDLE: nothing happens.
      start = 1'b1; abort = 1'b1; acc = 0;
      repeat (3) begin
         @(posedge clock);
         @(negedge clock);
         acc += busy + aborted + analyzer_clear;
      end
      start = 1'b0; abort = 1'b0;
      chk("start_abort_idle_activity", acc, 0);
      chk("start_abort_idle_valid", result_valid, 1);

      // start held high across three back-to-back runs.
      run_vec(vecs[2], 1'b1);
      run_vec(vecs[3], 1'b1);
      run_vec(vecs[0], 1'b1);
      start = 1'b0;
      @(posedge clock);
      @(negedge clock);
      chk("held_end_idle", busy, 0);
      chk("held_end_done_low", done, 0);

      // Asynchronous reset in the middle of MEASURE.
      window_cycles = 32'd100; f0_cfg = 32'd44; f0_value = 32'd55;
      start = 1'b1;
      @(posedge clock);
      @(negedge clock);
      start = 1'b0;
      repeat (20) begin
         @(posedge clock);
         @(negedge clock);
      end
      chk("pre_reset_enable", analyzer_enable, 1);
      #2 reset = 1'b0;
      #1 check_zero("mid_reset");
      @(negedge clock);
      reset = 1'b1;
      run_vec(vecs[4], 1'b0);

      chk("scoreboard_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
